// File: rtl/bf16_to_fp8_requant.sv
// bf16_to_fp8_requant: two-stage BF16 -> FP8 E4M3 requantizer with power-of-two scale.
// Define FP8_RNE_EN for round-to-nearest-even; the default build truncates.
module bf16_to_fp8_requant #(
    parameter int SCALE_W = 5,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [15:0]        in_data,
    input  logic [SCALE_W-1:0] scale_shift,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         out_data,
    input  logic               cnt_clr,
    output logic [CNT_W-1:0]   sat_count,
    output logic [CNT_W-1:0]   flush_count
);
    typedef enum logic [1:0] {CLS_NORM, CLS_ZERO, CLS_INF, CLS_NAN} cls_e;
    logic              v1_q, v1_d, v2_q, v2_d, adv1, adv2, fire, rnd;
    logic              s1_q, s1_d;
    logic signed [9:0] e1_q, e1_d, er;
    logic [2:0]        m1_q, m1_d;
    logic [3:0]        mr;
    cls_e              cls_q, cls_d;
`ifdef FP8_RNE_EN
    logic [1:0]        gs_q, gs_d;
`endif
    logic [7:0]        out_q, out_d;
    logic              sat_q, sat_d, flush_q, flush_d;
    logic [CNT_W-1:0]  sat_cnt_q, sat_cnt_d, flush_cnt_q, flush_cnt_d;

    assign adv2        = !v2_q || out_ready;
    assign adv1        = v1_q && adv2;
    assign in_ready    = !v1_q || adv2;
    assign fire        = v2_q && out_ready;
    assign out_valid   = v2_q;
    assign out_data    = out_q;
    assign sat_count   = sat_cnt_q;
    assign flush_count = flush_cnt_q;

`ifdef FP8_RNE_EN
    assign rnd = gs_q[1] && (gs_q[0] || m1_q[0]);
`else
    assign rnd = 1'b0;
`endif

    always_comb begin
        v1_d  = in_ready ? in_valid : v1_q;
        v2_d  = adv2 ? v1_q : v2_q;
        s1_d  = in_data[15];
        e1_d  = {2'b00, in_data[14:7]} - 10'd127 + {{(10-SCALE_W){scale_shift[SCALE_W-1]}}, scale_shift};
        m1_d  = in_data[6:4];
        cls_d = (in_data[14:7] == 8'h00) ? CLS_ZERO :
                (in_data[14:7] != 8'hFF) ? CLS_NORM :
                (|in_data[6:0])          ? CLS_NAN  : CLS_INF;
`ifdef FP8_RNE_EN
        gs_d  = {in_data[3], |in_data[2:0]};
`endif
    end

    // Flush is judged on the pre-rounding exponent; a mantissa carry bumps the exponent.
    always_comb begin
        mr      = {1'b0, m1_q} + {3'b000, rnd};
        er      = e1_q + {9'd0, mr[3]};
        flush_d = (cls_q == CLS_NORM) && (e1_q < -10'sd6);
        sat_d   = (cls_q == CLS_INF) || (cls_q == CLS_NAN) ||
                  ((cls_q == CLS_NORM) && !flush_d && ((er > 10'sd8) || ((er == 10'sd8) && (mr[2:0] == 3'b111))));
        out_d   = (cls_q == CLS_NAN)                ? 8'h7F :
                  ((cls_q == CLS_ZERO) || flush_d)  ? 8'h00 :
                  sat_d                             ? {s1_q, 7'h7E} :
                                                      {s1_q, er[3:0] + 4'd7, mr[2:0]};
    end

    always_comb begin
        sat_cnt_d   = cnt_clr ? '0 : (fire && sat_q && !(&sat_cnt_q)) ? sat_cnt_q + CNT_W'(1) : sat_cnt_q;
        flush_cnt_d = cnt_clr ? '0 : (fire && flush_q && !(&flush_cnt_q)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            s1_q        <= 1'b0;
            e1_q        <= '0;
            m1_q        <= '0;
            cls_q       <= CLS_ZERO;
`ifdef FP8_RNE_EN
            gs_q        <= '0;
`endif
            out_q       <= 8'h00;
            sat_q       <= 1'b0;
            flush_q     <= 1'b0;
            sat_cnt_q   <= '0;
            flush_cnt_q <= '0;
        end else begin
            v1_q        <= v1_d;
            v2_q        <= v2_d;
            sat_cnt_q   <= sat_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            if (in_valid && in_ready) begin
                s1_q  <= s1_d;
                e1_q  <= e1_d;
                m1_q  <= m1_d;
                cls_q <= cls_d;
`ifdef FP8_RNE_EN
                gs_q  <= gs_d;
`endif
            end
            if (adv1) begin
                out_q   <= out_d;
                sat_q   <= sat_d;
                flush_q <= flush_d;
            end
        end
    end
endmodule

// File: tb/tb_bf16_to_fp8_requant.sv
// tb_bf16_to_fp8_requant: directed plus randomized bench against a real-arithmetic reference model.
module tb_bf16_to_fp8_requant;
    localparam int SW = 5;
    localparam int CW = 16;
`ifdef FP8_RNE_EN
    localparam logic [7:0] EXP_1P1875 = 8'h3A;
    localparam logic [7:0] EXP_1P9375 = 8'h40;
`else
    localparam logic [7:0] EXP_1P1875 = 8'h39;
    localparam logic [7:0] EXP_1P9375 = 8'h3F;
`endif
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          cnt_clr = 1'b0;
    logic [15:0]   in_data = '0;
    logic [SW-1:0] scale_shift = '0;
    logic          in_ready, out_valid;
    logic [7:0]    out_data;
    logic [CW-1:0] sat_count, flush_count;
    int            checks = 0;
    int            failures = 0;
    logic [9:0]    q[$];
    int            mdl_sat = 0;
    int            mdl_flush = 0;
    logic [7:0]    last_out = '0;
    bit            stall_prev = 1'b0;

    bf16_to_fp8_requant #(.SCALE_W(SW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .scale_shift(scale_shift), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .cnt_clr(cnt_clr),
        .sat_count(sat_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic real pow2(input int e);
        real r = 1.0;
        if (e >= 0) repeat (e) r = r * 2.0;
        else repeat (-e) r = r / 2.0;
        return r;
    endfunction

    // Returns {flush, sat, byte}; works on the real value quantised to 4 significant bits.
    function automatic logic [9:0] ref_conv(input logic [15:0] x, input int sc);
        int ex, mt, e, fl;
        real mag, qv, fr, r;
        int up;
        logic s;
        s  = x[15];
        ex = int'(x[14:7]);
        mt = int'(x[6:0]);
        if (ex == 0) return 10'h000;
        if (ex == 255) return (mt != 0) ? 10'h17F : {2'b01, s, 7'h7E};
        e   = ex - 127 + sc;
        mag = (1.0 + mt / 128.0) * pow2(e);
        if (mag < pow2(-6)) return 10'h200;
        qv = mag / pow2(e - 3);
        fl = $rtoi(qv);
        fr = qv - fl;
`ifdef FP8_RNE_EN
        up = (fr > 0.5 || (fr == 0.5 && (fl % 2) == 1)) ? 1 : 0;
`else
        up = 0;
`endif
        r = (fl + up) * pow2(e - 3);
        if (r > 448.0) return {2'b01, s, 7'h7E};
        if (r >= pow2(e + 1)) e++;
        return {2'b00, s, 4'(e + 7), 3'($rtoi(r / pow2(e - 3)) - 8)};
    endfunction

    function automatic logic [15:0] rand_bf16();
        logic [7:0] ex;
        int k = $urandom_range(0, 9);
        ex = (k == 0) ? 8'h00 : (k == 1) ? 8'hFF : 8'(100 + $urandom_range(0, 59));
        return {1'($urandom), ex, 7'($urandom)};
    endfunction

    always @(negedge clk) begin
        logic [9:0] f;
        if (!rst_n) begin
            q.delete();
            mdl_sat = 0;
            mdl_flush = 0;
            stall_prev = 1'b0;
        end else begin
            check("sat_count", sat_count, mdl_sat);
            check("flush_count", flush_count, mdl_flush);
            if (stall_prev) check("stall_hold", out_data, last_out);
            if (out_valid) begin
                if (q.size() == 0) check("spurious_out", 1, 0);
                else check("out_data", out_data, q[0][7:0]);
            end
            f = 10'h000;
            if (out_valid && out_ready && q.size() > 0) f = q.pop_front();
            if (cnt_clr) begin
                mdl_sat = 0;
                mdl_flush = 0;
            end else begin
                if (f[8] && mdl_sat < 65535) mdl_sat++;
                if (f[9] && mdl_flush < 65535) mdl_flush++;
            end
            if (in_valid && in_ready) q.push_back(ref_conv(in_data, int'($signed(scale_shift))));
            stall_prev = out_valid && !out_ready;
            last_out = out_data;
        end
    end

    task automatic send(input logic [15:0] d, input int sc);
        int n = 0;
        bit fired = 1'b0;
        in_valid = 1'b1;
        in_data = d;
        scale_shift = SW'(sc);
        while (!fired && n < 50) begin
            @(negedge clk);
            fired = in_ready;
            n++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!fired) check("send_timeout", 0, 1);
    endtask

    task automatic xfer(input logic [15:0] d, input int sc, input logic [7:0] exp_b, input string tag);
        int n = 1;
        out_ready = 1'b1;
        send(d, sc);
        @(negedge clk);
        while (!out_valid && n < 8) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, n, 2);
        check(tag, out_data, exp_b);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        in_valid = 1'b0;
        cnt_clr = 1'b0;
        out_ready = 1'b1;
        while ((q.size() != 0 || out_valid) && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] held;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_sat", sat_count, 0);
        check("rst_flush", flush_count, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        xfer(16'h3F80, 0, 8'h38, "one");
        xfer(16'h3FC0, 0, 8'h3C, "one_half");
        xfer(16'h0000, 0, 8'h00, "zero");
        check("zero_sat", sat_count, 0);
        check("zero_flush", flush_count, 0);
        xfer(16'h3F98, 0, EXP_1P1875, "rnd_1p1875");
        xfer(16'h3F88, 0, 8'h38, "rnd_1p0625");
        xfer(16'h3FF8, 0, EXP_1P9375, "rnd_1p9375");
        xfer(16'h447A, 0, 8'h7E, "sat_pos");
        xfer(16'hC47A, 0, 8'hFE, "sat_neg");
        xfer(16'h7F80, 0, 8'h7E, "inf");
        xfer(16'h7FC1, 0, 8'h7F, "nan");
        check("sat_count4", sat_count, 4);
        xfer(16'h3C00, 0, 8'h00, "flush");
        check("flush_count1", flush_count, 1);
        xfer(16'h3C80, 0, 8'h08, "min_norm");
        xfer(16'h3F80, 3, 8'h50, "scale_p3");
        xfer(16'h3F80, -7, 8'h00, "scale_m7");
        check("flush_count2", flush_count, 2);
        // Backpressure: three inputs against a stalled consumer.
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 16'h3F80;
        scale_shift = '0;
        @(negedge clk);
        check("bp_rdy0", in_ready, 1);
        @(posedge clk);
        #1;
        in_data = 16'h3FC0;
        @(negedge clk);
        check("bp_rdy1", in_ready, 1);
        @(posedge clk);
        #1;
        in_data = 16'h4000;
        @(negedge clk);
        check("bp_full", in_ready, 0);
        check("bp_head", out_data, 8'h38);
        held = out_data;
        repeat (3) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check("bp_hold", out_data, held);
            check("bp_rdy", in_ready, 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release", in_ready, 1);
        @(posedge clk);
        #1;
        drain();
        // Reset with two elements in flight.
        out_ready = 1'b0;
        send(16'h3F80, 0);
        send(16'h3FC0, 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_sat", sat_count, 0);
        check("mid_rst_flush", flush_count, 0);
        check("mid_rst_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        xfer(16'h4000, 0, 8'h40, "post_rst");
        // Clear colliding with a saturating handshake.
        xfer(16'h7F80, 0, 8'h7E, "inf2");
        check("sat_before_clr", sat_count, 1);
        send(16'h447A, 0);
        @(posedge clk);
        #1;
        cnt_clr = 1'b1;
        @(negedge clk);
        check("clr_out_valid", out_valid, 1);
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        check("clr_wins", sat_count, 0);
        // Randomized traffic with random backpressure and occasional clears.
        repeat (800) begin
            in_valid = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            cnt_clr = ($urandom_range(0, 49) == 0);
            in_data = rand_bf16();
            scale_shift = SW'($urandom);
            @(posedge clk);
            #1;
        end
        drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
